// File: rtl/cont_display_if.sv
// Counter-observation bus between the upstream 4-bit counter, the wrap/epoch
// tracker and the two-digit seven-segment display.
interface cont_display_if;
    logic [3:0] count_in;
    logic       load;
    logic       dir_up;
    logic       epoch_clr;
    logic       wrap_up;
    logic       wrap_dn;
    logic [3:0] epoch;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output count_in, load, dir_up, epoch_clr,
        input  wrap_up, wrap_dn, epoch, seg, an
    );

    modport slave (
        input  count_in, load, dir_up, epoch_clr,
        output wrap_up, wrap_dn, epoch, seg, an
    );
endinterface

// File: rtl/cont_display.sv
// Watches an upstream 4-bit counter for F->0 / 0->F wraps, keeps a modulo-16
// epoch of them and multiplexes count (low digit) and epoch (high digit) onto a display.
module cont_display #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input logic            ck,
    input logic            reset,
    cont_display_if.slave  bus
);
    localparam logic [15:0] DIV_M1 = 16'(REFRESH_DIV - 1);

    logic [3:0]  prev_q, prev_d;
    logic        load_q, load_d;
    logic        dir_q, dir_d;
    logic        valid_q, valid_d;
    logic        wrap_up_q, wrap_up_d;
    logic        wrap_dn_q, wrap_dn_d;
    logic [3:0]  epoch_q, epoch_d;
    logic [15:0] refresh_q, refresh_d;
    logic        sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic [3:0]  disp_val;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        prev_d  = bus.count_in;
        load_d  = bus.load;
        dir_d   = bus.dir_up;
        valid_d = 1'b1;

        // load_q/dir_q are the controls that produced the change now visible on count_in
        wrap_up_d = valid_q && (prev_q == 4'hF) && (bus.count_in == 4'h0) && !load_q && dir_q;
        wrap_dn_d = valid_q && (prev_q == 4'h0) && (bus.count_in == 4'hF) && !load_q && !dir_q;

        epoch_d = epoch_q;
        if (bus.epoch_clr)
            epoch_d = 4'h0;
        else if (wrap_up_d)
            epoch_d = epoch_q + 4'h1;
        else if (wrap_dn_d)
            epoch_d = epoch_q - 4'h1;

        refresh_d = refresh_q + 16'd1;
        sel_d     = sel_q;
        if (refresh_q == DIV_M1) begin
            refresh_d = 16'd0;
            sel_d     = ~sel_q;
        end

        disp_val = sel_q ? epoch_q : prev_q;
        seg_d    = hex7(disp_val);
        an_d     = sel_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            prev_q    <= 4'h0;
            load_q    <= 1'b0;
            dir_q     <= 1'b0;
            valid_q   <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
            epoch_q   <= 4'h0;
            refresh_q <= 16'd0;
            sel_q     <= 1'b0;
            seg_q     <= 7'b1000000;
            an_q      <= 2'b10;
        end else begin
            prev_q    <= prev_d;
            load_q    <= load_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
            epoch_q   <= epoch_d;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.wrap_up = wrap_up_q;
    assign bus.wrap_dn = wrap_dn_q;
    assign bus.epoch   = epoch_q;
    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
endmodule

// File: tb/tb_cont_display.sv
// Directed bench for cont_display: expected per-edge results are queued with the
// stimulus and popped against the outputs sampled just after each rising edge.
module tb_cont_display;
    logic ck = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    cont_display_if bus();

    cont_display #(.REFRESH_DIV(4)) dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ck = ~ck;

    typedef struct {
        string      tag;
        logic       wu;
        logic       wd;
        logic [3:0] ep;
        bit         cd;
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sbq[$];

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_A = 7'b0001000;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge ck);
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".wrap_up"}, {6'd0, bus.wrap_up}, {6'd0, e.wu});
        chk({e.tag, ".wrap_dn"}, {6'd0, bus.wrap_dn}, {6'd0, e.wd});
        chk({e.tag, ".epoch"}, {3'd0, bus.epoch}, {3'd0, e.ep});
        if (e.cd) begin
            chk({e.tag, ".an"}, {5'd0, bus.an}, {5'd0, e.an});
            chk({e.tag, ".seg"}, bus.seg, e.seg);
        end
    endtask

    task automatic step(input string tag, input logic wu, input logic wd, input logic [3:0] ep);
        exp_t e;
        e = '{tag: tag, wu: wu, wd: wd, ep: ep, cd: 1'b0, an: 2'b00, seg: 7'd0};
        sbq.push_back(e);
        tick();
    endtask

    task automatic step_d(input string tag, input logic wu, input logic wd, input logic [3:0] ep,
                          input logic [1:0] an, input logic [6:0] seg);
        exp_t e;
        e = '{tag: tag, wu: wu, wd: wd, ep: ep, cd: 1'b1, an: an, seg: seg};
        sbq.push_back(e);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ep;
        logic [1:0] last_an;
        bit         found;

        reset             = 1'b1;
        bus.count_in      = 4'h0;
        bus.load          = 1'b0;
        bus.dir_up        = 1'b0;
        bus.epoch_clr     = 1'b0;
        step_d("rst0", 1'b0, 1'b0, 4'h0, 2'b10, SEG_0);
        step_d("rst1", 1'b0, 1'b0, 4'h0, 2'b10, SEG_0);

        // up-wrap F -> 0
        reset = 1'b0; bus.count_in = 4'hF; bus.dir_up = 1'b1;
        step("up_pre", 1'b0, 1'b0, 4'h0);
        bus.count_in = 4'h0;
        step("up_wrap", 1'b1, 1'b0, 4'h1);
        step("up_hold", 1'b0, 1'b0, 4'h1);

        bus.epoch_clr = 1'b1;
        step("clr", 1'b0, 1'b0, 4'h0);
        bus.epoch_clr = 1'b0;

        // down-wrap 0 -> F from epoch 0
        bus.dir_up = 1'b0; bus.count_in = 4'h0;
        step("dn_pre", 1'b0, 1'b0, 4'h0);
        bus.count_in = 4'hF;
        step("dn_wrap", 1'b0, 1'b1, 4'hF);
        step("dn_hold", 1'b0, 1'b0, 4'hF);

        // load F then 0: no pulse
        bus.load = 1'b1; bus.dir_up = 1'b1; bus.count_in = 4'hF;
        step("ld_pre", 1'b0, 1'b0, 4'hF);
        bus.load = 1'b0; bus.count_in = 4'h0;
        step("ld_f_to_0", 1'b0, 1'b0, 4'hF);
        bus.count_in = 4'h7;
        step("chg_0_7", 1'b0, 1'b0, 4'hF);
        bus.count_in = 4'h8;
        step("chg_7_8", 1'b0, 1'b0, 4'hF);

        // epoch F + 1 wraps to 0
        bus.count_in = 4'hF;
        step("epF_pre", 1'b0, 1'b0, 4'hF);
        bus.count_in = 4'h0;
        step("epF_wrap", 1'b1, 1'b0, 4'h0);

        ep = 4'h0;
        for (int i = 0; i < 5; i++) begin
            bus.count_in = 4'hF;
            step("to5_pre", 1'b0, 1'b0, ep);
            ep = ep + 4'h1;
            bus.count_in = 4'h0;
            step("to5_wrap", 1'b1, 1'b0, ep);
        end

        // clear coincident with an up-wrap: pulse still emitted, epoch forced to 0
        bus.count_in = 4'hF;
        step("clrw_pre", 1'b0, 1'b0, 4'h5);
        bus.count_in = 4'h0; bus.epoch_clr = 1'b1;
        step("clr_wrap", 1'b1, 1'b0, 4'h0);
        bus.epoch_clr = 1'b0;

        // walk epoch down to A for the display check
        bus.dir_up = 1'b0;
        ep = 4'h0;
        for (int i = 0; i < 6; i++) begin
            bus.count_in = 4'h0;
            step("toA_pre", 1'b0, 1'b0, ep);
            ep = ep - 4'h1;
            bus.count_in = 4'hF;
            step("toA_wrap", 1'b0, 1'b1, ep);
        end

        bus.count_in = 4'h3;
        step("disp_set", 1'b0, 1'b0, 4'hA);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            last_an = bus.an;
            step("disp_sync", 1'b0, 1'b0, 4'hA);
            if (last_an == 2'b01 && bus.an == 2'b10)
                found = 1'b1;
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL disp_sync observed=no an 01->10 edge expected=edge within 12 cycles");
        end
        chk("disp_lo0.seg", bus.seg, SEG_3);
        for (int i = 0; i < 3; i++) step_d("disp_lo", 1'b0, 1'b0, 4'hA, 2'b10, SEG_3);
        for (int i = 0; i < 4; i++) step_d("disp_hi", 1'b0, 1'b0, 4'hA, 2'b01, SEG_A);
        for (int i = 0; i < 4; i++) step_d("disp_lo2", 1'b0, 1'b0, 4'hA, 2'b10, SEG_3);

        // reset lands on the edge that would detect F -> 0
        bus.dir_up = 1'b1; bus.count_in = 4'hF;
        step("rstw_pre", 1'b0, 1'b0, 4'hA);
        bus.count_in = 4'h0; reset = 1'b1;
        step_d("rst_mid", 1'b0, 1'b0, 4'h0, 2'b10, SEG_0);

        // first edge after reset: valid_q=0 hides the 0 -> F transition
        reset = 1'b0; bus.dir_up = 1'b0; bus.count_in = 4'hF;
        step("post_rst1", 1'b0, 1'b0, 4'h0);
        step("post_rst2", 1'b0, 1'b0, 4'h0);
        bus.count_in = 4'h0;
        step("post_rst3", 1'b0, 1'b0, 4'h0);
        bus.count_in = 4'hF;
        step("post_rst_dn", 1'b0, 1'b1, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cont_display.md
CONT_DISPLAY -- requirements
Module: cont_display

Interface
REQ-001 The block SHALL have exactly one clock, ck, and a synchronous, active-high reset, reset; all state SHALL change only on the rising edge of ck.
REQ-002 Parameter REFRESH_DIV, default 1000: ck cycles each display digit stays selected; legal range 2..65535.
REQ-003 Port ck  input  1  system clock.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port count_in  input  4  count value from the upstream 4-bit up/down/load counter.
REQ-006 Port load  input  1  the upstream counter's load control; 1 means the next count change is a load.
REQ-007 Port dir_up  input  1  the upstream counter's count-direction control; 1 means up, 0 means down.
REQ-008 Port epoch_clr  input  1  synchronous clear of the epoch counter.
REQ-009 Port wrap_up  output  1  one-cycle pulse on an up-count wrap from F to 0.
REQ-010 Port wrap_dn  output  1  one-cycle pulse on a down-count wrap from 0 to F.
REQ-011 Port epoch  output  4  signed-free modulo-16 count of wraps; the high display digit.
REQ-012 Port seg  output  7  active-low segments; seg[0]=a through seg[6]=g.
REQ-013 Port an  output  2  active-low digit enables; an[0] is the low digit and an[1] is the high digit.

Function
REQ-014 On every edge, the block SHALL register count_in into prev, load into load_q, and dir_up into dir_q, and SHALL set valid_q to 1.
REQ-015 wrap_up SHALL be registered to 1 for exactly one cycle when valid_q=1, prev=4'hF, count_in=4'h0, load_q=0 and dir_q=1; otherwise it SHALL be 0.
REQ-016 wrap_dn SHALL be registered to 1 for exactly one cycle when valid_q=1, prev=4'h0, count_in=4'hF, load_q=0 and dir_q=0; otherwise it SHALL be 0.
REQ-017 Each wrap pulse SHALL appear one cycle after count_in first shows the post-wrap value; wrap_up and wrap_dn SHALL never be 1 together.
REQ-018 A transition caused by a load (load_q=1) SHALL never generate a wrap pulse, whatever its values.
REQ-019 A count that holds its value, or changes other than F->0 or 0->F, SHALL generate no pulse.
REQ-020 epoch SHALL update on the same edge as the pulse: +1 for an up-wrap and -1 for a down-wrap, modulo 16 (F+1=0, 0-1=F).
REQ-021 epoch_clr=1 SHALL force epoch to 0 on the next edge, with priority over a coincident wrap; the wrap pulse itself SHALL still be emitted.
REQ-022 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-023 On the wrap of the refresh counter, digit select sel SHALL toggle.
REQ-024 While sel=0, an SHALL be 2'b10 and seg SHALL show the hex pattern of prev.
REQ-025 While sel=1, an SHALL be 2'b01 and seg SHALL show the hex pattern of epoch.
REQ-026 seg and an SHALL be registered and change together, one cycle after sel or the displayed value changes.
REQ-027 Hex patterns (active-low, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.

Reset
REQ-028 reset=1 at an edge SHALL set prev=0, load_q=0, dir_q=0, valid_q=0, wrap_up=0, wrap_dn=0, epoch=0, refresh counter=0, sel=0, an=2'b10 and seg=7'b1000000.
REQ-029 reset SHALL take priority over all other inputs, including epoch_clr and a pending wrap.
REQ-030 After a mid-operation reset, a wrap pulse SHALL first be possible on the second edge after reset deasserts, because valid_q=0 suppresses detection on the first edge.

Verification
REQ-031 The bench SHALL drive reset, then count_in F, dir_up=1, load=0, then count_in 0; it SHALL require wrap_up=1 for one cycle and epoch=1.
REQ-032 From epoch=0, the bench SHALL drive count_in 0 then F with dir_up=0; it SHALL require wrap_dn=1 for one cycle and epoch=F.
REQ-033 The bench SHALL drive count_in F with load=1, then count_in 0; it SHALL require no pulse and no change to epoch.
REQ-034 The bench SHALL assert epoch_clr=1 in the same cycle as an up-wrap detection with epoch=5; it SHALL require wrap_up=1 and epoch=0.
REQ-035 With REFRESH_DIV=4, prev=3 and epoch=A, an SHALL alternate 10/01 every 4 cycles, with seg=0110000 and seg=0001000 respectively.
REQ-036 The bench SHALL assert reset during the cycle an F->0 transition would be detected; it SHALL require no pulse, epoch=0, and the reset values of REQ-028.
